hand_tracker: RTL and testbench
===============================

Name: hand_tracker

Overview:
- Parametrised successor to the per-player hand controller. Stores up to MAX_CARDS card ranks and keeps hard and best (soft-ace-adjusted) totals.
- Flags bust, natural blackjack, soft hand and N-card Charlie, and closes the hand automatically when play must stop.
- Sits between the dealer/deck FSM, which offers cards with a valid/ready handshake, and the game-outcome comparator and display logic.

Parameters:
- MAX_CARDS, 5: card slots; Charlie count. Legal range 2..8.
- CARD_W, 4: rank code width. Codes 1=Ace, 2..10 pips, 11..13 = J/Q/K.
- SUM_W, 6: width of the total outputs. Must satisfy 2^SUM_W-1 >= 10*MAX_CARDS.
- CNT_W, $clog2(MAX_CARDS+1): card-count width (derived).

Ports:
- i_clk, input, 1: clock, rising edge.
- i_reset_n, input, 1: one clock; reset is synchronous and active-low.
- i_add_valid, input, 1: card offered this cycle.
- i_new_card, input, CARD_W: rank code of the offered card.
- o_add_ready, output, 1: hand can accept a card.
- i_stand, input, 1: player stands (level sampled each edge).
- o_cards, output, MAX_CARDS*CARD_W: slot k occupies bits [k*CARD_W +: CARD_W]; unused slots read 0.
- o_num_cards, output, CNT_W: cards held.
- o_hard_sum, output, SUM_W: total with every Ace counted as 1 and face cards as 10.
- o_best_sum, output, SUM_W: hard_sum+10 if an Ace is held and hard_sum<=11; otherwise hard_sum.
- o_soft, output, 1: the +10 Ace adjustment is applied.
- o_bust, output, 1: hard_sum > 21.
- o_blackjack, output, 1: exactly 2 cards and best_sum == 21.
- o_charlie, output, 1: num_cards == MAX_CARDS and not bust.
- o_done, output, 1: hand closed (state DONE).
- o_reject, output, 1: one-cycle pulse; a card was offered while not ready, or the rank code was illegal.

Behaviour:
- States: OPEN, DONE. Reset (i_reset_n==0 at an edge) forces OPEN, clears all slots, count, sums and ace flag, and clears o_reject. Reset overrides every other input, including mid-hand.
- After reset: o_add_ready=1; every other output is 0.
- Handshake:
  - A card is accepted on an edge where i_add_valid && o_add_ready && rank is in 1..13.
  - o_add_ready = (state==OPEN). It is combinational from state only and does not depend on i_add_valid.
  - Offered card with rank 0 or 14..15 while ready: not stored, o_reject=1 the next cycle, state unchanged.
  - Offered card while DONE: not stored, o_reject=1 the next cycle.
- Accept edge, all registered in one update:
  - slot[num_cards] <= rank; num_cards += 1.
  - hard_sum += value, where value = 10 for ranks 11..13 and the rank otherwise.
  - ace_seen |= (rank==1).
- Output timing: derived flags (best_sum, soft, bust, blackjack, charlie) are combinational from registers. They reflect the new card in the cycle right after the accept edge (0-cycle latency after the edge).
- Closing the hand: the transition OPEN->DONE is evaluated on the post-accept (next-state) values. It happens on the accept edge itself when any of these holds:
  - next bust;
  - next best_sum == 21;
  - next num_cards == MAX_CARDS.
- i_stand high at an edge while OPEN -> DONE.
  - Stand together with an accepted card: the card is stored first, then the hand closes.
  - Stand while DONE is ignored.
- DONE is held until reset; contents are frozen.
- Arithmetic: hard_sum saturates at 2^SUM_W-1 and never wraps. It cannot overflow with legal parameters; saturation is a guard only.
- Blackjack is only possible at num_cards==2. A 3-card 21 sets best_sum 21 and done, but not o_blackjack.
- Charlie and bust are mutually exclusive. A 21 reached on the MAX_CARDS-th card sets both o_charlie and done.

Test Plan:
- Reset, then Ace then King on consecutive edges -> after edge 2: hard 11, best 21, soft=1, blackjack=1, done=1, ready=0, num=2.
- Cards 10, 6, 9 -> after the 9: hard 25, bust=1, done=1, best 25, soft=0. A further offered card gives reject pulse=1 and num stays 3.
- MAX_CARDS=5; cards 2, 3, 2, 4, 2 -> hard 13, charlie=1, done=1. A sixth offer is rejected. Repeat with MAX_CARDS=3 and cards 2, 2, 2 -> charlie after 3.
- Ace, 5 -> best 16, soft=1. Then 9 -> hard 15, best 15, soft=0, done=0.
- Card 7 with i_stand high on the same edge -> num=1, hard 7, done=1. Illegal rank 14 offered before that edge -> reject pulse, no slot written.
- Mid-hand (2 cards held), drive i_reset_n=0 for one edge while i_add_valid=1 -> all outputs 0 except ready=1, and the card is not stored.

Source files
------------

// File: rtl/hand_tracker.sv
// hand_tracker: per-player card hand. Holds up to MAX_CARDS rank codes and
// keeps the hard total and an ace flag. All derived flags are decoded
// combinationally from those registers. The hand closes itself when play
// must stop: bust, a 21, a full hand, or the player standing.
module hand_tracker #(
  parameter  int MAX_CARDS = 5,
  parameter  int CARD_W    = 4,
  parameter  int SUM_W     = 6,
  localparam int CNT_W     = $clog2(MAX_CARDS + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_add_valid,
  input  logic [CARD_W-1:0]           i_new_card,
  output logic                        o_add_ready,
  input  logic                        i_stand,
  output logic [MAX_CARDS*CARD_W-1:0] o_cards,
  output logic [CNT_W-1:0]            o_num_cards,
  output logic [SUM_W-1:0]            o_hard_sum,
  output logic [SUM_W-1:0]            o_best_sum,
  output logic                        o_soft,
  output logic                        o_bust,
  output logic                        o_blackjack,
  output logic                        o_charlie,
  output logic                        o_done,
  output logic                        o_reject
);

  typedef enum logic {OPEN, DONE} state_t;

  state_t                        state;
  logic [MAX_CARDS*CARD_W-1:0]   cards_q;
  logic [CNT_W-1:0]              num_q;
  logic [SUM_W-1:0]              hard_q;
  logic                          ace_q;
  logic                          reject_q;

  logic                          rank_legal;
  logic                          accept;
  logic [CARD_W-1:0]             value;
  logic [SUM_W:0]                sum_ext;
  logic [SUM_W-1:0]              next_hard;
  logic [CNT_W-1:0]              next_num;
  logic                          next_ace;
  logic                          close_hand;

  // An Ace counts 11 only when that cannot push the hand past 21.
  function automatic logic soft_of(input logic [SUM_W-1:0] h, input logic a);
    return a && (h <= SUM_W'(11));
  endfunction

  function automatic logic [SUM_W-1:0] best_of(input logic [SUM_W-1:0] h, input logic a);
    return soft_of(h, a) ? h + SUM_W'(10) : h;
  endfunction

  // Accept decision and post-accept values used to decide closing the hand.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rank_legal = (i_new_card != '0) && (i_new_card <= CARD_W'(13));
    accept     = i_add_valid && (state == OPEN) && rank_legal;
    value      = (i_new_card > CARD_W'(10)) ? CARD_W'(10) : i_new_card;
    sum_ext    = {1'b0, hard_q} + (SUM_W + 1)'(value);
    // Saturate rather than wrap; unreachable with legal parameters.
    next_hard  = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    next_num   = num_q + CNT_W'(1);
    next_ace   = ace_q || (i_new_card == CARD_W'(1));
    close_hand = i_stand;
    if (accept &&
        ((next_hard > SUM_W'(21)) ||
         (best_of(next_hard, next_ace) == SUM_W'(21)) ||
         (next_num == CNT_W'(MAX_CARDS)))) begin
      close_hand = 1'b1;
    end
  end

  // Hand state, storage and reject pulse.
  always_ff @(posedge i_clk) begin
    // NOTE: card storage is reset too, because unused slots must read back as 0.
    if (!i_reset_n) begin
      state    <= OPEN;
      cards_q  <= '0;
      num_q    <= '0;
      hard_q   <= '0;
      ace_q    <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      reject_q <= i_add_valid && ((state != OPEN) || !rank_legal);
      if (state == OPEN) begin
        if (accept) begin
          for (int k = 0; k < MAX_CARDS; k++) begin
            if (num_q == CNT_W'(k)) cards_q[k*CARD_W +: CARD_W] <= i_new_card;
          end
          num_q  <= next_num;
          hard_q <= next_hard;
          ace_q  <= next_ace;
        end
        if (close_hand) state <= DONE;
      end
    end
  end

  // Outputs decoded from the registered hand.
  always_comb begin
    o_add_ready = (state == OPEN);
    o_cards     = cards_q;
    o_num_cards = num_q;
    o_hard_sum  = hard_q;
    o_best_sum  = best_of(hard_q, ace_q);
    o_soft      = soft_of(hard_q, ace_q);
    o_bust      = hard_q > SUM_W'(21);
    o_blackjack = (num_q == CNT_W'(2)) && (best_of(hard_q, ace_q) == SUM_W'(21));
    o_charlie   = (num_q == CNT_W'(MAX_CARDS)) && !(hard_q > SUM_W'(21));
    o_done      = (state == DONE);
    o_reject    = reject_q;
  end

endmodule

// File: tb/tb_hand_tracker.sv
// Directed bench for hand_tracker: a default 5-slot instance plus a 3-slot
// instance sharing the same stimulus, for the Charlie check at MAX_CARDS=3.
module tb_hand_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        add_valid;
  logic [3:0]  new_card;
  logic        stand;

  logic        ready5, soft5, bust5, bj5, charlie5, done5, reject5;
  logic [19:0] cards5;
  logic [2:0]  num5;
  logic [5:0]  hard5, best5;

  logic        ready3, soft3, bust3, bj3, charlie3, done3, reject3;
  logic [11:0] cards3;
  logic [1:0]  num3;
  logic [5:0]  hard3, best3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hand_tracker dut5 (
    .i_clk(clk), .i_reset_n(rst_n), .i_add_valid(add_valid), .i_new_card(new_card),
    .o_add_ready(ready5), .i_stand(stand), .o_cards(cards5), .o_num_cards(num5),
    .o_hard_sum(hard5), .o_best_sum(best5), .o_soft(soft5), .o_bust(bust5),
    .o_blackjack(bj5), .o_charlie(charlie5), .o_done(done5), .o_reject(reject5)
  );

  hand_tracker #(.MAX_CARDS(3)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_add_valid(add_valid), .i_new_card(new_card),
    .o_add_ready(ready3), .i_stand(stand), .o_cards(cards3), .o_num_cards(num3),
    .o_hard_sum(hard3), .o_best_sum(best3), .o_soft(soft3), .o_bust(bust3),
    .o_blackjack(bj3), .o_charlie(charlie3), .o_done(done3), .o_reject(reject3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    add_valid = 1'b0;
    new_card  = 4'd0;
    stand     = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic offer(input logic [3:0] card, input logic st);
    add_valid = 1'b1;
    new_card  = card;
    stand     = st;
    step();
    add_valid = 1'b0;
    stand     = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_ready", ready5, 1);
    check("rst_cards", cards5, 0);
    check("rst_num", num5, 0);
    check("rst_hard", hard5, 0);
    check("rst_best", best5, 0);
    check("rst_flags", {soft5, bust5, bj5, charlie5, done5, reject5}, 0);

    // Ace then King: natural blackjack
    offer(4'd1, 1'b0);
    check("ak_best1", best5, 11);
    check("ak_soft1", soft5, 1);
    check("ak_done1", done5, 0);
    offer(4'd13, 1'b0);
    check("ak_hard", hard5, 11);
    check("ak_best", best5, 21);
    check("ak_soft", soft5, 1);
    check("ak_bj", bj5, 1);
    check("ak_done", done5, 1);
    check("ak_ready", ready5, 0);
    check("ak_num", num5, 2);
    check("ak_cards", cards5, 20'h000D1);

    // 10, 6, 9: bust, then a rejected offer
    do_reset();
    offer(4'd10, 1'b0);
    offer(4'd6, 1'b0);
    check("b_hard16", hard5, 16);
    check("b_done16", done5, 0);
    offer(4'd9, 1'b0);
    check("b_hard", hard5, 25);
    check("b_best", best5, 25);
    check("b_bust", bust5, 1);
    check("b_soft", soft5, 0);
    check("b_done", done5, 1);
    check("b_charlie", charlie5, 0);
    offer(4'd5, 1'b0);
    check("b_reject", reject5, 1);
    check("b_num", num5, 3);
    step();
    check("b_reject_pulse", reject5, 0);

    // 2, 3, 2, 4, 2: five-card Charlie
    do_reset();
    offer(4'd2, 1'b0);
    offer(4'd3, 1'b0);
    offer(4'd2, 1'b0);
    offer(4'd4, 1'b0);
    check("c_done4", done5, 0);
    offer(4'd2, 1'b0);
    check("c_hard", hard5, 13);
    check("c_num", num5, 5);
    check("c_charlie", charlie5, 1);
    check("c_done", done5, 1);
    check("c_cards", cards5, 20'h24232);
    offer(4'd3, 1'b0);
    check("c_reject6", reject5, 1);
    check("c_num6", num5, 5);

    // 2, 2, 2: three-card Charlie on the MAX_CARDS=3 instance
    do_reset();
    offer(4'd2, 1'b0);
    offer(4'd2, 1'b0);
    check("c3_done2", done3, 0);
    offer(4'd2, 1'b0);
    check("c3_charlie", charlie3, 1);
    check("c3_done", done3, 1);
    check("c3_hard", hard3, 6);
    check("c3_cards", cards3, 12'h222);
    check("c5_open", {done5, charlie5}, 0);

    // 7, 7, 7: three-card 21 closes the hand but is not blackjack
    do_reset();
    offer(4'd7, 1'b0);
    offer(4'd7, 1'b0);
    offer(4'd7, 1'b0);
    check("t21_best", best5, 21);
    check("t21_done", done5, 1);
    check("t21_bj", bj5, 0);

    // Ace, 5 soft 16, then 9 hardens to 15
    do_reset();
    offer(4'd1, 1'b0);
    offer(4'd5, 1'b0);
    check("s_best16", best5, 16);
    check("s_soft16", soft5, 1);
    offer(4'd9, 1'b0);
    check("s_hard", hard5, 15);
    check("s_best", best5, 15);
    check("s_soft", soft5, 0);
    check("s_done", done5, 0);

    // Illegal rank 14, then 7 with stand on the same edge
    do_reset();
    offer(4'd14, 1'b0);
    check("i_reject", reject5, 1);
    check("i_num", num5, 0);
    check("i_cards", cards5, 0);
    check("i_ready", ready5, 1);
    offer(4'd7, 1'b1);
    check("st_num", num5, 1);
    check("st_hard", hard5, 7);
    check("st_done", done5, 1);
    check("st_reject", reject5, 0);
    stand = 1'b1;
    step();
    stand = 1'b0;
    check("st_hold", {done5, num5}, {1'b1, 3'd1});

    // Reset mid-hand while a card is offered
    do_reset();
    offer(4'd3, 1'b0);
    offer(4'd4, 1'b0);
    check("mr_num2", num5, 2);
    rst_n     = 1'b0;
    add_valid = 1'b1;
    new_card  = 4'd5;
    step();
    rst_n     = 1'b1;
    add_valid = 1'b0;
    check("mr_ready", ready5, 1);
    check("mr_cards", cards5, 0);
    check("mr_num", num5, 0);
    check("mr_sums", {hard5, best5}, 0);
    check("mr_flags", {soft5, bust5, bj5, charlie5, done5, reject5}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
